// File: rtl/i2s.sv
// I2S transmitter: free-running bit clock divider, 2*SLOT_BITS-bit frame,
// left/right samples latched at frame start and shifted out MSB first,
// one bclk after the lrclk change.
module i2s #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left,
  input  logic [DATA_WIDTH-1:0] right,
  output logic                  dout,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  load
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int B_W   = $clog2(FRAME);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
  localparam logic [B_W-1:0]   SLOT     = B_W'(SLOT_BITS);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [B_W-1:0]        b_q, b_d;
  logic                  lrclk_q, lrclk_d;
  logic                  dout_q, dout_d;
  logic                  load_q, load_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] lh_q, lh_d;
  logic [DATA_WIDTH-1:0] rh_q, rh_d;

  logic                  wrap;
  logic [B_W-1:0]        k;
  logic [DATA_WIDTH-1:0] sample;

  // Divider, bit counter, serializer and capture control.
  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    b_d     = b_q;
    lrclk_d = lrclk_q;
    dout_d  = dout_q;
    load_d  = 1'b0;
    pend_d  = pend_q;
    lh_d    = lh_q;
    rh_d    = rh_q;
    wrap    = 1'b0;
    k       = b_q;
    sample  = lh_q;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      // Falling bclk: advance the frame position and present the next bit,
      // so the receiver sees stable data on the following rising edge.
      if (bclk_q) begin
        wrap    = (b_q == B_LAST);
        b_d     = wrap ? '0 : b_q + B_W'(1);
        lrclk_d = (b_d >= SLOT);
        k       = lrclk_d ? b_d - SLOT : b_d;
        sample  = lrclk_d ? rh_q : lh_q;
        // Slot bit 0 and everything past the sample are padding zeros.
        dout_d  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (k == B_W'(DATA_WIDTH - i)) dout_d = sample[i];
        end
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Latch both channels at frame start (or first edge out of reset); the
    // new sample is first used at slot bit 1, so the frame boundary is clean.
    if (pend_q || wrap) begin
      lh_d   = left;
      rh_d   = right;
      load_d = 1'b1;
      pend_d = 1'b0;
    end
  end

  // State registers; reset parks everything at frame start with a capture armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      b_q     <= '0;
      lrclk_q <= 1'b0;
      dout_q  <= 1'b0;
      load_q  <= 1'b0;
      pend_q  <= 1'b1;
      lh_q    <= '0;
      rh_q    <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      b_q     <= b_d;
      lrclk_q <= lrclk_d;
      dout_q  <= dout_d;
      load_q  <= load_d;
      pend_q  <= pend_d;
      lh_q    <= lh_d;
      rh_q    <= rh_d;
    end
  end

  assign dout  = dout_q;
  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;
  assign load  = load_q;

endmodule

// File: tb/tb_i2s.sv
// Bench for i2s: random samples checked every clk edge against a frame-level
// model (edge count -> bclk phase, bit position, slot, expected bit).
module tb_i2s;

  localparam int DW   = 24;
  localparam int S    = 32;
  localparam int CDIV = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] left, right;
  logic          dout, bclk, lrclk, load;

  int checks = 0;
  int errors = 0;
  int n;                       // rising edges since reset release
  logic [DW-1:0] hl, hr;       // model holding registers

  i2s #(.DATA_WIDTH(DW), .SLOT_BITS(S), .CLK_DIV(CDIV)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .dout(dout), .bclk(bclk), .lrclk(lrclk), .load(load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Advance one clk edge, update the model, compare every output.
  task automatic step(input int chg_pct);
    int falls, b, k;
    logic e_dout, e_lr, e_bclk, e_load;
    logic [DW-1:0] smp;
    @(posedge clk);
    #1;
    n++;
    e_load = (n == 1) || (n % (4 * S * CDIV) == 0);
    if (e_load) begin
      hl = left;
      hr = right;
    end
    falls  = n / (2 * CDIV);
    e_bclk = ((n / CDIV) % 2) == 1;
    b      = falls % (2 * S);
    e_lr   = (b >= S);
    k      = b % S;
    smp    = e_lr ? hr : hl;
    e_dout = (k >= 1 && k <= DW) ? smp[DW-k] : 1'b0;
    chk("bclk",  {31'd0, bclk},  {31'd0, e_bclk});
    chk("lrclk", {31'd0, lrclk}, {31'd0, e_lr});
    chk("load",  {31'd0, load},  {31'd0, e_load});
    chk("dout",  {31'd0, dout},  {31'd0, e_dout});
    if ($urandom_range(99) < chg_pct) begin
      left  = DW'($urandom);
      right = DW'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bclk"},  {31'd0, bclk},  32'd0);
    chk({tag, "_lrclk"}, {31'd0, lrclk}, 32'd0);
    chk({tag, "_dout"},  {31'd0, dout},  32'd0);
    chk({tag, "_load"},  {31'd0, load},  32'd0);
  endtask

  initial begin
    n     = 0;
    hl    = '0;
    hr    = '0;
    left  = 24'hAAAAAA;
    right = 24'hF0F0F0;
    reset = 1'b1;

    // Reset held 20 ns: outputs quiet throughout.
    #1 chk_zero("rst_t1");
    #18 chk_zero("rst_t19");
    #1 reset = 1'b0;   // t=20, next rising edge (t=25) is edge 1

    // Frame 0 with fixed patterns; left changed mid-frame at edge 40.
    while (n < 128) begin
      step(0);
      if (n == 1)  chk("load_edge1",   {31'd0, load},  32'd1);
      if (n == 2)  chk("msb_edge2",    {31'd0, dout},  32'd1);
      if (n == 4)  chk("bit2_edge4",   {31'd0, dout},  32'd0);
      if (n == 50) chk("pad_edge50",   {31'd0, dout},  32'd0);
      if (n == 64) chk("lr_rise64",    {31'd0, lrclk}, 32'd1);
      if (n == 66) chk("rmsb_edge66",  {31'd0, dout},  32'd1);
      if (n == 74) chk("r5_edge74",    {31'd0, dout},  32'd0);
      if (n == 40) left = 24'h555555;
      if (n == 127) chk("lr_hi127",    {31'd0, lrclk}, 32'd1);
    end
    chk("lr_fall128", {31'd0, lrclk}, 32'd0);
    chk("load128",    {31'd0, load},  32'd1);
    step(0);
    chk("load_once129", {31'd0, load}, 32'd0);
    step(0);
    chk("newleft_msb130", {31'd0, dout}, 32'd0);  // 0x555555 MSB is 0

    // Random samples, changing at random times, over several frames.
    while (n < 3 * 128 + 70) step(4);

    // Asynchronous reset mid right slot (edge 70 of a frame).
    chk("lr_before_rst", {31'd0, lrclk}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("rst_hold");
    left  = DW'($urandom) | 24'h800000;
    right = DW'($urandom);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    step(0);
    step(0);
    chk("msb_after_rst", {31'd0, dout}, 32'd1);
    while (n < 2 * 128 + 10) step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
